// File: rtl/iob_pfsm_loader_pkg.sv
// Shared definitions for the PFSM program loader.
// Holds the loader state encoding, the default bytes-per-word constant and
// the IOb write-strobe constants (all-ones marks a write, zero a read).
package iob_pfsm_loader_pkg;

  // Loader sequence states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_SET = 3'd1,
    FETCH   = 3'd2,
    WRITE   = 3'd3,
    READ    = 3'd4,
    RB_WAIT = 3'd5,
    RST_CLR = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int DEF_DATA_W = 32;

  // Bytes per IOb data word for a given data width
  function automatic int n_bytes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int N_BYTES = n_bytes(DEF_DATA_W);

  localparam logic [N_BYTES-1:0] WSTRB_WR = '1;
  localparam logic [N_BYTES-1:0] WSTRB_RD = '0;

endpackage

// File: rtl/iob_reg_r.sv
// Generic IOb register with clock enable, asynchronous active-low reset and
// synchronous clear.
// Ports:
//   clk_i    - clock
//   cke_i    - clock enable; register holds when low
//   arst_n_i - asynchronous active-low reset to RST_VAL
//   rst_i    - synchronous clear to RST_VAL (honoured only when cke_i is high)
//   data_i   - next value
//   data_o   - registered value
module iob_reg_r #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Clock-enabled storage; the synchronous clear takes priority over new data
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= rst_i ? RST_VAL : data_i;
    end
  end

endmodule

// File: rtl/iob_pfsm_loader.sv
// IOb-native initiator that programs a PFSM (or compatible responder) from a
// word stream: asserts SOFTRESET, writes len words from PROG_BASE_ADDR on,
// optionally reads each one back and compares, then releases SOFTRESET.
// Ports:
//   clk_i, cke_i, arst_n_i           - clock, clock enable, async active-low reset
//   start_i, len_i, verify_i         - sequence start and its latched arguments
//   s_valid_i, s_data_i, s_ready_o   - program word stream
//   busy_o, done_o, err_o            - status (done is a pulse, err is sticky)
//   iob_avalid_o .. iob_wstrb_o      - IOb request channel
//   iob_rvalid_i, iob_rdata_i        - IOb read response
//   iob_ready_i                      - IOb request accept
module iob_pfsm_loader
  import iob_pfsm_loader_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int LEN_W          = 16,
  parameter int SOFTRESET_ADDR = 0,
  parameter int PROG_BASE_ADDR = 16
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  verify_i,
  input  logic                  s_valid_i,
  input  logic [DATA_W-1:0]     s_data_i,
  output logic                  s_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i
);

  localparam int NB    = n_bytes(DATA_W);
  localparam int SHIFT = $clog2(NB);

  localparam logic [NB-1:0] STRB_WR = {NB{WSTRB_WR[0]}};
  localparam logic [NB-1:0] STRB_RD = {NB{WSTRB_RD[0]}};

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          state_q;
  logic [LEN_W-1:0]    k;
  logic [LEN_W-1:0]    k_nxt;
  logic [LEN_W-1:0]    k_inc;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    len_nxt;
  logic                verify;
  logic                verify_nxt;
  logic                err;
  logic                err_nxt;
  logic [DATA_W-1:0]   word;
  logic [DATA_W-1:0]   word_nxt;
  logic [ADDR_W-1:0]   prog_addr;

  iob_reg_r #(.DATA_W(3)) state_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(state_nxt), .data_o(state_q)
  );

  iob_reg_r #(.DATA_W(LEN_W)) k_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(k_nxt), .data_o(k)
  );

  iob_reg_r #(.DATA_W(LEN_W)) len_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(len_nxt), .data_o(len)
  );

  iob_reg_r #(.DATA_W(1)) verify_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(verify_nxt), .data_o(verify)
  );

  iob_reg_r #(.DATA_W(1)) err_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(err_nxt), .data_o(err)
  );

  iob_reg_r #(.DATA_W(DATA_W)) word_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(1'b0),
    .data_i(word_nxt), .data_o(word)
  );

  assign state = state_t'(state_q);
  assign k_inc = k + LEN_W'(1);

  // Word k lives at a byte offset of k*NB; the sum wraps at ADDR_W bits
  assign prog_addr = ADDR_W'(PROG_BASE_ADDR) + (ADDR_W'(k) << SHIFT);

  assign err_o = err;

  // Next-state and request generation. Every request is a pure function of
  // the registered state, counter and captured word, so it stays stable
  // while the responder stalls and while cke_i freezes the registers.
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    len_nxt      = len;
    verify_nxt   = verify;
    err_nxt      = err;
    word_nxt     = word;
    s_ready_o    = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = STRB_RD;

    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          len_nxt    = len_i;
          verify_nxt = verify_i;
          err_nxt    = 1'b0;
          k_nxt      = '0;
          state_nxt  = RST_SET;
        end
      end
      RST_SET: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(SOFTRESET_ADDR);
        iob_wdata_o  = DATA_W'(1);
        iob_wstrb_o  = STRB_WR;
        if (iob_ready_i) begin
          state_nxt = (len != '0) ? FETCH : RST_CLR;
        end
      end
      FETCH: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          word_nxt  = s_data_i;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = prog_addr;
        iob_wdata_o  = word;
        iob_wstrb_o  = STRB_WR;
        if (iob_ready_i) begin
          if (verify) begin
            state_nxt = READ;
          end else begin
            k_nxt     = k_inc;
            state_nxt = (k_inc == len) ? RST_CLR : FETCH;
          end
        end
      end
      READ: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = prog_addr;
        iob_wstrb_o  = STRB_RD;
        if (iob_ready_i) begin
          state_nxt = RB_WAIT;
        end
      end
      RB_WAIT: begin
        if (iob_rvalid_i) begin
          if (iob_rdata_i != word) begin
            err_nxt = 1'b1;
          end
          k_nxt     = k_inc;
          state_nxt = (k_inc == len) ? RST_CLR : FETCH;
        end
      end
      RST_CLR: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(SOFTRESET_ADDR);
        iob_wdata_o  = '0;
        iob_wstrb_o  = STRB_WR;
        if (iob_ready_i) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_o    = 1'b0;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_pfsm_loader.sv
// Self-checking bench for iob_pfsm_loader: a table of run scenarios with
// hand-computed transaction traces, plus hand-written reset-abort and
// cke-freeze/ignored-start sequences.
module tb_iob_pfsm_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic                clk = 1'b0;
  logic                cke;
  logic                arst_n;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic                verify;
  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_ready;
  logic                busy;
  logic                done;
  logic                err;
  logic                iob_avalid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic                iob_rvalid;
  logic [DATA_W-1:0]   iob_rdata;
  logic                iob_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_pfsm_loader dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
    .start_i(start), .len_i(len), .verify_i(verify),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .busy_o(busy), .done_o(done), .err_o(err),
    .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr),
    .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
    .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata),
    .iob_ready_i(iob_ready)
  );

  // Responder and stream source models
  logic [31:0]       mem [0:1023];
  logic [3:0][31:0]  curWords;
  int                streamIdx;
  int                stallCnt;
  int                bubCnt;
  bit                stallMode;
  bit                bubbleMode;
  bit                corruptEn;
  bit                modelClear;
  logic [ADDR_W-1:0] corruptAddr;
  logic              rvalidQ;
  logic [31:0]       rdataQ;

  assign iob_ready  = !stallMode || !(iob_avalid && iob_wstrb != '0 && iob_addr != '0) || stallCnt == 4;
  assign s_valid    = !bubbleMode || bubCnt == 3;
  assign s_data     = curWords[streamIdx[1:0]];
  assign iob_rvalid = rvalidQ;
  assign iob_rdata  = rdataQ;

  // Responder memory with one-cycle read latency, optional write stalls and
  // a corrupting read address; stream source with optional 3-cycle bubbles
  always @(posedge clk) begin
    if (modelClear) begin
      streamIdx <= 0;
      stallCnt  <= 0;
      bubCnt    <= 0;
      rvalidQ   <= 1'b0;
      rdataQ    <= '0;
    end else begin
      rvalidQ <= 1'b0;
      if (cke && iob_avalid && iob_ready) begin
        stallCnt <= 0;
        if (iob_wstrb != '0) begin
          mem[iob_addr[ADDR_W-1:2]] <= iob_wdata;
        end else begin
          rvalidQ <= 1'b1;
          rdataQ  <= (corruptEn && iob_addr == corruptAddr) ? 32'hFFFF0000 : mem[iob_addr[ADDR_W-1:2]];
        end
      end else if (cke && iob_avalid && stallCnt < 4) begin
        stallCnt <= stallCnt + 1;
      end
      if (cke && s_ready && s_valid) begin
        streamIdx <= streamIdx + 1;
        bubCnt    <= 0;
      end else if (cke && s_ready && bubCnt < 3) begin
        bubCnt <= bubCnt + 1;
      end
    end
  end

  // Transaction monitor: logs every accepted request with its cycle number
  // relative to the start edge and watches request stability during stalls
  int                edgeCount = 0;
  int                startEdge = 0;
  logic              logWe   [0:63];
  logic [ADDR_W-1:0] logAddr [0:63];
  logic [31:0]       logData [0:63];
  int                logCyc  [0:63];
  int                logN = 0;
  int                doneCycle = -1;
  bit                sreadySeen = 0;
  int                stableErrs = 0;
  bit                prevPending = 0;
  logic [ADDR_W-1:0] prevAddr;
  logic [31:0]       prevData;
  logic [3:0]        prevStrb;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(negedge clk) begin
    if (modelClear) begin
      logN        = 0;
      doneCycle   = -1;
      sreadySeen  = 0;
      prevPending = 0;
    end else if (arst_n) begin
      if (prevPending && (!iob_avalid || iob_addr != prevAddr || iob_wdata != prevData || iob_wstrb != prevStrb)) begin
        stableErrs++;
      end
      prevPending = iob_avalid && !(iob_ready && cke);
      prevAddr    = iob_addr;
      prevData    = iob_wdata;
      prevStrb    = iob_wstrb;
      if (cke && iob_avalid && iob_ready && logN < 64) begin
        logWe[logN]   = (iob_wstrb != '0);
        logAddr[logN] = iob_addr;
        logData[logN] = iob_wdata;
        logCyc[logN]  = edgeCount - startEdge + 1;
        logN++;
      end
      if (done && doneCycle < 0) doneCycle = edgeCount - startEdge + 1;
      if (s_ready) sreadySeen = 1;
    end
  end

  typedef struct {
    int               len;
    bit               verify;
    bit               stall;
    bit               bubble;
    int               corruptIdx;
    bit               checkTiming;
    int               expDone;
    bit               expErr;
    logic [3:0][31:0] words;
  } vec_t;

  vec_t vecs [0:3];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearModels();
    @(negedge clk);
    #1 modelClear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 modelClear = 1'b0;
  endtask

  // Pulses start for one edge; afterwards time sits just past edge 0
  task automatic applyStimulus(input int n, input bit v);
    start  = 1'b1;
    len    = LEN_W'(n);
    verify = v;
    @(posedge clk);
    #1;
    startEdge = edgeCount;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (doneCycle >= 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [52:0] allOutputs();
    return {s_ready, busy, done, err, iob_avalid, iob_addr, iob_wdata, iob_wstrb};
  endfunction

  task automatic runScenario(input vec_t v, input string tag);
    logic              eWe   [0:63];
    logic [ADDR_W-1:0] eAddr [0:63];
    logic [31:0]       eData [0:63];
    int                eCyc  [0:63];
    int                n;
    int                per;
    bit                ok;

    n = 0;
    per = v.verify ? 4 : 2;
    eWe[n] = 1; eAddr[n] = 0; eData[n] = 32'd1; eCyc[n] = 1; n++;
    for (int i = 0; i < v.len; i++) begin
      eWe[n] = 1; eAddr[n] = ADDR_W'(16 + 4 * i); eData[n] = v.words[i]; eCyc[n] = 3 + per * i; n++;
      if (v.verify) begin
        eWe[n] = 0; eAddr[n] = ADDR_W'(16 + 4 * i); eData[n] = 32'd0; eCyc[n] = 4 + per * i; n++;
      end
    end
    eWe[n] = 1; eAddr[n] = 0; eData[n] = 32'd0; eCyc[n] = per * v.len + 2; n++;

    curWords    = v.words;
    stallMode   = v.stall;
    bubbleMode  = v.bubble;
    corruptEn   = (v.corruptIdx >= 0);
    corruptAddr = ADDR_W'(16 + 4 * v.corruptIdx);
    clearModels();
    applyStimulus(v.len, v.verify);

    @(negedge clk);
    #1;
    checkOutput({tag, " busy_after_start"}, busy, 1);
    checkOutput({tag, " err_cleared_at_start"}, err, 0);

    waitDone(2000, ok);
    checkOutput({tag, " done_seen"}, ok, 1);
    if (v.expDone > 0) checkOutput({tag, " done_cycle"}, doneCycle, v.expDone);
    @(negedge clk);
    #1;
    checkOutput({tag, " done_one_cycle"}, {done, busy}, 2'b00);
    checkOutput({tag, " err"}, err, v.expErr);
    checkOutput({tag, " txn_count"}, logN, n);
    for (int j = 0; j < n && j < logN; j++) begin
      checkOutput($sformatf("%s txn%0d", tag, j), {logWe[j], logAddr[j], logData[j]}, {eWe[j], eAddr[j], eData[j]});
      if (v.checkTiming) checkOutput($sformatf("%s txn%0d_cycle", tag, j), logCyc[j], eCyc[j]);
    end
    if (v.len == 0) checkOutput({tag, " s_ready_never"}, sreadySeen, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit   ok;
    vec_t v;

    vecs[0] = '{len: 3, verify: 0, stall: 0, bubble: 0, corruptIdx: -1, checkTiming: 1,
                expDone: 9, expErr: 0, words: {32'h0, 32'hC3, 32'hB2, 32'hA1}};
    vecs[1] = '{len: 0, verify: 0, stall: 0, bubble: 0, corruptIdx: -1, checkTiming: 1,
                expDone: 3, expErr: 0, words: {32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[2] = '{len: 2, verify: 1, stall: 0, bubble: 0, corruptIdx: 1, checkTiming: 1,
                expDone: 11, expErr: 1, words: {32'h0, 32'h0, 32'h0000FFFF, 32'h12345678}};
    vecs[3] = '{len: 3, verify: 0, stall: 1, bubble: 1, corruptIdx: -1, checkTiming: 0,
                expDone: -1, expErr: 0, words: {32'h0, 32'hC3, 32'hB2, 32'hA1}};

    cke = 1'b1; arst_n = 1'b0; start = 1'b0; len = '0; verify = 1'b0;
    stallMode = 0; bubbleMode = 0; corruptEn = 0; corruptAddr = '0;
    modelClear = 1'b0; curWords = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 53'd0);
    #1 arst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_outputs", allOutputs(), 53'd0);

    for (int i = 0; i < 4; i++) begin
      runScenario(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted during the second program write of a len=4 run
    curWords = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    stallMode = 0; bubbleMode = 0; corruptEn = 0;
    clearModels();
    applyStimulus(4, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (iob_avalid && iob_addr == ADDR_W'(20)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("abort_reached_second_write", ok, 1);
    arst_n = 1'b0;
    #1;
    checkOutput("abort_outputs_async", allOutputs(), 53'd0);
    repeat (2) @(negedge clk);
    #1 arst_n = 1'b1;
    v = '{len: 4, verify: 0, stall: 0, bubble: 0, corruptIdx: -1, checkTiming: 1,
          expDone: 11, expErr: 0, words: {32'hD4, 32'hC3, 32'hB2, 32'hA1}};
    runScenario(v, "after_abort");

    // Start pulsed while busy, then cke low for 5 cycles during FETCH of k=1
    curWords = {32'h0, 32'hC3, 32'hB2, 32'hA1};
    clearModels();
    applyStimulus(3, 0);
    @(negedge clk);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 cke = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("freeze_holds_outputs", {s_ready, busy, iob_avalid}, 3'b110);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 cke = 1'b1;
    waitDone(200, ok);
    checkOutput("freeze_done_seen", ok, 1);
    checkOutput("freeze_done_cycle", doneCycle, 14);
    checkOutput("freeze_txn_count", logN, 5);
    checkOutput("freeze_txn0", {logWe[0], logAddr[0], logData[0], 8'(logCyc[0])}, {1'b1, 12'd0,  32'd1,    8'd1});
    checkOutput("freeze_txn1", {logWe[1], logAddr[1], logData[1], 8'(logCyc[1])}, {1'b1, 12'd16, 32'hA1,   8'd3});
    checkOutput("freeze_txn2", {logWe[2], logAddr[2], logData[2], 8'(logCyc[2])}, {1'b1, 12'd20, 32'hB2,   8'd10});
    checkOutput("freeze_txn3", {logWe[3], logAddr[3], logData[3], 8'(logCyc[3])}, {1'b1, 12'd24, 32'hC3,   8'd12});
    checkOutput("freeze_txn4", {logWe[4], logAddr[4], logData[4], 8'(logCyc[4])}, {1'b1, 12'd0,  32'd0,    8'd13});

    checkOutput("request_stability", stableErrs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
